// File: rtl/arb_types.sv
// Shared types for the instruction/data memory arbiter.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
`timescale 1ns/1ps
package arb_types;

  // Arbiter FSM: one memory transaction in flight at most
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;

  // Data grants allowed back-to-back while a fetch waits
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  // Memory port is word addressed; byte offset is carried by the mask
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto one memory port; data has priority
// until a fetch has waited STARVE_LIMIT data grants. Latency: m_* registered,
// one cycle after grant; *_resp is combinational from m_resp. Backpressure:
// requesters hold until their *_resp; one IDLE cycle separates transactions.
// Optional stall counters: define MEM_ARB_PERF_EN.
`timescale 1ns/1ps
module mem_arbiter
  import arb_types::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [31:0]       i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_mbe,
  output logic [31:0]       d_rdata,
  output logic              d_resp,
  output logic              m_read,
  output logic              m_write,
  output logic [31:0]       m_addr,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_mbe,
  input  logic [31:0]       m_rdata,
  input  logic              m_resp
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_d_wait,
  output logic [CNT_W-1:0]  perf_i_wait
`endif
);

  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          grant_i, grant_d;
  logic          d_req;

  logic          m_read_q, m_write_q;
  logic [31:0]   m_addr_q, m_wdata_q;
  logic [3:0]    m_mbe_q;

  // Byte offset bits never reach memory
  logic          unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

  assign d_req = d_read | d_write;

  // FSM state and fetch-starvation count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Grant decision in IDLE, return to IDLE on memory completion
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req && !(i_read && (starve_q == STARVE_MAX))) begin
          grant_d = 1'b1;
          state_d = D_BUSY;
          if (i_read && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
          end
        end else if (i_read) begin
          grant_i  = 1'b1;
          state_d  = I_BUSY;
          starve_d = '0;
        end
      end
      I_BUSY, D_BUSY: begin
        if (m_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Completion pulses go straight from m_resp to the owning requester
  always_comb begin
    i_resp  = 1'b0;
    d_resp  = 1'b0;
    i_rdata = m_rdata;
    d_rdata = m_rdata;
    case (state_q)
      I_BUSY:  i_resp = m_resp;
      D_BUSY:  d_resp = m_resp;
      default: ;
    endcase
  end

  // Memory port registers: load on grant, clear once memory completes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_mbe_q   <= '0;
    end else if (grant_i) begin
      m_read_q  <= 1'b1;
      m_write_q <= 1'b0;
      m_addr_q  <= word_align(i_addr);
      m_wdata_q <= '0;
      m_mbe_q   <= 4'hF;
    end else if (grant_d) begin
      // read+write together is a write
      m_read_q  <= d_read & ~d_write;
      m_write_q <= d_write;
      m_addr_q  <= word_align(d_addr);
      m_wdata_q <= d_wdata;
      m_mbe_q   <= d_mbe;
    end else if ((state_q != IDLE) && m_resp) begin
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_mbe_q   <= '0;
    end
  end

  assign m_read  = m_read_q;
  assign m_write = m_write_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_mbe   = m_mbe_q;

`ifdef MEM_ARB_PERF_EN
  logic [CNT_W-1:0] perf_d_q, perf_i_q;

  // Stall counters: cycles a request is up without its completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_d_q <= '0;
      perf_i_q <= '0;
    end else begin
      if (d_req && !d_resp) begin
        perf_d_q <= perf_d_q + CNT_W'(1);
      end
      if (i_read && !i_resp) begin
        perf_i_q <= perf_i_q + CNT_W'(1);
      end
    end
  end

  assign perf_d_wait = perf_d_q;
  assign perf_i_wait = perf_i_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
